// File: rtl/mod_n_counter_hex.sv
// mod_n_counter_hex
//   Modulo-N up/down counter with built-in prescaler, synchronous load and a
//   two-digit active-low seven-segment output. It replaces the separate
//   divider, counter and decoder stages.
//
// Parameters
//   CLK_DIV  clock cycles per count tick (>= 2)
//   MODULUS  count range 0..MODULUS-1 (>= 2)
//   WIDTH    count width (2**WIDTH >= MODULUS, WIDTH <= 8)
//
// Ports
//   CLOCK_50  in   sole clock, rising edge
//   reset     in   synchronous active-high reset
//   en        in   1 = prescaler runs and count advances on tick, 0 = hold
//   up_dn     in   1 = count up, 0 = count down (sampled on the tick cycle)
//   load      in   synchronous load strobe (beats a coincident tick)
//   load_val  in   load value, clamped to MODULUS-1
//   count     out  registered count
//   tick      out  one-cycle prescaler pulse
//   tc        out  one-cycle wrap pulse, aligned with the wrapped count
//   HEX0      out  segments {g..a}, active low, low nibble of count
//   HEX1      out  segments {g..a}, active low, high nibble of count
//
// Build option
//   MOD_COUNTER_LEAD_BLANK_EN  when defined, HEX1 is blanked while the high
//                              nibble is zero; HEX0 is never blanked.

module mod_n_counter_hex #(
   parameter int CLK_DIV = 25000000,
   parameter int MODULUS = 8,
   parameter int WIDTH   = 4
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tick,
   output logic             tc,
   output logic [6:0]       HEX0,
   output logic [6:0]       HEX1
);

   localparam int               PW      = $clog2(CLK_DIV);
   localparam logic [PW-1:0]    PS_LAST = PW'(CLK_DIV - 1);
   localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
   localparam logic [6:0]       SEG_0   = 7'b1000000;
   localparam logic [6:0]       SEG_OFF = 7'b1111111;

`ifdef MOD_COUNTER_LEAD_BLANK_EN
   localparam logic [6:0] HI_RESET = SEG_OFF;
`else
   localparam logic [6:0] HI_RESET = SEG_0;
`endif

   logic [PW-1:0]    presc;
   logic [WIDTH-1:0] count_next;
   logic             wrap;
   logic [7:0]       count_ext;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'h0:    seg7 = 7'b1000000;
         4'h1:    seg7 = 7'b1111001;
         4'h2:    seg7 = 7'b0100100;
         4'h3:    seg7 = 7'b0110000;
         4'h4:    seg7 = 7'b0011001;
         4'h5:    seg7 = 7'b0010010;
         4'h6:    seg7 = 7'b0000010;
         4'h7:    seg7 = 7'b1111000;
         4'h8:    seg7 = 7'b0000000;
         4'h9:    seg7 = 7'b0010000;
         4'hA:    seg7 = 7'b0001000;
         4'hB:    seg7 = 7'b0000011;
         4'hC:    seg7 = 7'b1000110;
         4'hD:    seg7 = 7'b0100001;
         4'hE:    seg7 = 7'b0000110;
         default: seg7 = 7'b0001110;
      endcase
   endfunction

   // Tick is decoded straight from the prescaler so the step lands on the
   // edge that ends the tick cycle.
   assign tick = en && (presc == PS_LAST);

   always_comb begin
      count_next = count;
      wrap       = 1'b0;
      if (up_dn) begin
         if (count == TOP) begin
            count_next = '0;
            wrap       = 1'b1;
         end else begin
            count_next = count + 1'b1;
         end
      end else begin
         if (count == '0) begin
            count_next = TOP;
            wrap       = 1'b1;
         end else begin
            count_next = count - 1'b1;
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         presc <= '0;
         count <= '0;
         tc    <= 1'b0;
      end else if (load) begin
         // Load restarts the prescaler so the next step is a full period away.
         count <= ({1'b0, load_val} >= MOD_EXT) ? TOP : load_val;
         presc <= '0;
         tc    <= 1'b0;
      end else begin
         tc <= 1'b0;
         if (en) begin
            presc <= (presc == PS_LAST) ? '0 : presc + 1'b1;
         end
         if (tick) begin
            count <= count_next;
            tc    <= wrap;
         end
      end
   end

   assign count_ext = 8'(count);

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         HEX0 <= SEG_0;
         HEX1 <= HI_RESET;
      end else begin
         HEX0 <= seg7(count_ext[3:0]);
`ifdef MOD_COUNTER_LEAD_BLANK_EN
         HEX1 <= (count_ext[7:4] == 4'h0) ? SEG_OFF : seg7(count_ext[7:4]);
`else
         HEX1 <= seg7(count_ext[7:4]);
`endif
      end
   end

endmodule

// File: doc/mod_n_counter_hex.md
# mod_n_counter_hex

Parametrised modulo-N up/down counter with built-in prescaler, synchronous load and two-digit seven-segment output. It is the generalised successor of the fixed mod-8 counter/display chain and sits between the board clock (CLOCK_50) and the HEX displays. One instance replaces the divider, counter and decoder trio. Modulus, width and tick rate are set per instance.

## Interface
Parameters:
- CLK_DIV, 25000000: CLOCK_50 cycles per count tick; must be ≥ 2.
- MODULUS, 8: count range 0..MODULUS-1; must be ≥ 2.
- WIDTH, 4: count width; must satisfy 2^WIDTH ≥ MODULUS and WIDTH ≤ 8.

Ports:
- CLOCK_50  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  1 = prescaler runs and count advances on tick; 0 = hold.
- up_dn  in  1  1 = count up, 0 = count down; sampled on the tick cycle.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value for load.
- count  out  WIDTH  current count, registered.
- tick  out  1  one-cycle prescaler pulse.
- tc  out  1  one-cycle terminal-count (wrap) pulse.
- HEX0  out  7  active-low segments {g..a}, low nibble of count.
- HEX1  out  7  active-low segments {g..a}, high nibble of count (zero-extended).

## Operation
- Priority per cycle: reset > load > tick step > hold.
- Prescaler: counter ceil(log2(CLK_DIV)) bits, runs 0..CLK_DIV-1 while en=1, frozen while en=0. tick=1 in the cycle the prescaler holds CLK_DIV-1 with en=1; the prescaler then returns to 0.
- Step (tick=1, no load): up: count = (count==MODULUS-1) ? 0 : count+1. Down: count = (count==0) ? MODULUS-1 : count-1.
- tc: registered and asserted for exactly one cycle, aligned with the count update that performs a wrap (MODULUS-1→0 up, 0→MODULUS-1 down).
- Load: count ← load_val; if load_val ≥ MODULUS, count ← MODULUS-1 (clamp). The prescaler clears to 0. tc is not asserted. Load acts regardless of en.
- up_dn changing between ticks has no effect until the next tick.
- Decoder: glyphs 0–F, with 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- HEX outputs are registered from count and lag count by one cycle.

## Timing
- Reset (synchronous, one edge): count=0, prescaler=0, tick=0, tc=0, HEX0=1000000, HEX1=1000000 (1111111 with blanking enabled).
- Tick-to-count latency: count updates on the edge ending the tick=1 cycle; tc is high in the following cycle together with the new count.
- Count-to-HEX latency: 1 cycle.
- Continuous en=1 gives a step period of exactly CLK_DIV cycles.
- Load and tick in the same cycle: load wins and the step is dropped.
- Reset mid-count or mid-prescale: all state returns to reset values on that edge. The next tick arrives CLK_DIV cycles after reset releases with en=1.

## Configuration
- MOD_COUNTER_LEAD_BLANK_EN:
  - Defined: HEX1 shows 1111111 (blank) whenever the high nibble is 0.
  - Undefined: HEX1 always shows the high-nibble glyph, including 0.
  - HEX0 is unaffected in both cases.

## Test plan
- Reset/defaults: CLK_DIV=4, MODULUS=8; hold reset 3 cycles -> count=0, tick=0, tc=0, HEX0=1000000.
- Up wrap: en=1, up_dn=1 for 40 cycles from reset -> tick every 4th cycle; count 0,1,…,7,0,1; tc high exactly one cycle, with count=0 after 7; HEX0=1111000 one cycle after count=7.
- Down wrap and hold: from count=0, en=1, up_dn=0 -> next step gives count=7 with tc=1; then en=0 for 20 cycles -> count and prescaler frozen, tick=0.
- Load/clamp/priority: load=1, load_val=5 -> count=5 next edge, prescaler=0. load_val=12 with MODULUS=8, WIDTH=4 -> count=7. Load coinciding with tick -> count=load value, no step, tc=0.
- Two-digit and blanking: MODULUS=200, WIDTH=8, load 0xA7 -> HEX1=0001000, HEX0=1111000. Load 0x05 -> HEX1=1111111 with MOD_COUNTER_LEAD_BLANK_EN defined, 1000000 without.
- Reset mid-operation: assert reset while count=6 and prescaler=2 -> next edge count=0, tc=0. First tick comes 4 cycles after release.
